// File: rtl/traditional_multiplier8_xor_enc32.sv
// traditional_multiplier8_xor_enc32
// 8x8 unsigned Wallace-tree multiplier with 32 XOR key gates on the even-column
// partial products pp[k/4][2*(k%4)]. With keyinput == KEY_CORRECT the gates
// cancel and result_o is the exact 16-bit product. Any other key flips the
// corresponding partial-product bits before reduction, so the product is
// corrupted deterministically.
// Optional build macro: TRADMUL8_PIPE_EN inserts a register stage between the
// Wallace reduction (two rows + valid) and the final ripple adder (latency 2).
// Without it there is a single output register (latency 1).
module traditional_multiplier8_xor_enc32 #(
  parameter logic [31:0] KEY_CORRECT = 32'h62FEDB15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  operand1_i,
  input  logic [7:0]  operand2_i,
  input  logic [31:0] keyinput,
  input  logic        valid_i,
  output logic [15:0] result_o,
  output logic        valid_o
);

  // pp[i][j] = a[i] & b[j], weight 2^(i+j), after key gating
  logic [7:0]  pp [8];
  // the two rows left after Wallace reduction
  logic [15:0] row_a;
  logic [15:0] row_b;
  // operands of the final carry-propagate adder
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_v;
  logic [15:0] sum;

  // reduction working storage: per-column bit stacks and heights
  logic [15:0] col_cur [16];
  logic [15:0] col_nxt [16];
  logic [4:0]  h_cur   [16];
  logic [4:0]  h_nxt   [16];

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // partial-product generation with XOR key gates on even columns of b
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        pp[i][j] = operand1_i[i] & operand2_i[j];
        if ((j % 2) == 0) begin
          pp[i][j] = pp[i][j] ^ keyinput[i*4 + j/2] ^ KEY_CORRECT[i*4 + j/2];
        end
      end
    end
  end

  // Wallace reduction: every stage compresses each column with full adders on
  // groups of three and a half adder on a leftover pair, until no column is
  // taller than two. Carries out of column 15 fall off (mod 2^16).
  always_comb begin
    logic [1:0] r;
    logic [4:0] idx;
    logic       busy;

    r    = 2'b00;
    idx  = 5'd0;
    busy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      col_cur[c] = '0;
      col_nxt[c] = '0;
      h_cur[c]   = 5'd0;
      h_nxt[c]   = 5'd0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col_cur[i+j][h_cur[i+j][3:0]] = pp[i][j];
        h_cur[i+j] = h_cur[i+j] + 5'd1;
      end
    end

    // 8 rows need four Wallace stages; extra iterations do nothing once done
    for (int st = 0; st < 6; st++) begin
      busy = 1'b0;
      for (int c = 0; c < 16; c++) begin
        if (h_cur[c] > 5'd2) busy = 1'b1;
      end
      if (busy) begin
        for (int c = 0; c < 16; c++) begin
          col_nxt[c] = '0;
          h_nxt[c]   = 5'd0;
        end
        for (int c = 0; c < 16; c++) begin
          idx = 5'd0;
          for (int g = 0; g < 5; g++) begin
            if (idx + 5'd3 <= h_cur[c]) begin
              r = full_add(col_cur[c][idx[3:0]], col_cur[c][idx[3:0] + 4'd1],
                           col_cur[c][idx[3:0] + 4'd2]);
              col_nxt[c][h_nxt[c][3:0]] = r[0];
              h_nxt[c] = h_nxt[c] + 5'd1;
              if (c < 15) begin
                col_nxt[c+1][h_nxt[c+1][3:0]] = r[1];
                h_nxt[c+1] = h_nxt[c+1] + 5'd1;
              end
              idx = idx + 5'd3;
            end
          end
          if (h_cur[c] - idx == 5'd2) begin
            r = half_add(col_cur[c][idx[3:0]], col_cur[c][idx[3:0] + 4'd1]);
            col_nxt[c][h_nxt[c][3:0]] = r[0];
            h_nxt[c] = h_nxt[c] + 5'd1;
            if (c < 15) begin
              col_nxt[c+1][h_nxt[c+1][3:0]] = r[1];
              h_nxt[c+1] = h_nxt[c+1] + 5'd1;
            end
          end else if (h_cur[c] - idx == 5'd1) begin
            col_nxt[c][h_nxt[c][3:0]] = col_cur[c][idx[3:0]];
            h_nxt[c] = h_nxt[c] + 5'd1;
          end
        end
        for (int c = 0; c < 16; c++) begin
          col_cur[c] = col_nxt[c];
          h_cur[c]   = h_nxt[c];
        end
      end
    end

    for (int c = 0; c < 16; c++) begin
      row_a[c] = (h_cur[c] >= 5'd1) ? col_cur[c][0] : 1'b0;
      row_b[c] = (h_cur[c] >= 5'd2) ? col_cur[c][1] : 1'b0;
    end
  end

`ifdef TRADMUL8_PIPE_EN
  logic [15:0] row_a_q;
  logic [15:0] row_b_q;
  logic        row_v_q;

  // reduction-to-adder pipeline register; rows hold while no operation is valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_a_q <= '0;
      row_b_q <= '0;
      row_v_q <= 1'b0;
    end else begin
      row_v_q <= valid_i;
      if (valid_i) begin
        row_a_q <= row_a;
        row_b_q <= row_b;
      end
    end
  end

  assign add_a = row_a_q;
  assign add_b = row_b_q;
  assign add_v = row_v_q;
`else
  assign add_a = row_a;
  assign add_b = row_b;
  assign add_v = valid_i;
`endif

  // 16-bit ripple-carry final adder
  always_comb begin
    logic carry;
    carry = 1'b0;
    for (int c = 0; c < 16; c++) begin
      sum[c] = add_a[c] ^ add_b[c] ^ carry;
      carry  = (add_a[c] & add_b[c]) | (add_a[c] & carry) | (add_b[c] & carry);
    end
  end

  // output register; result holds its last value while no operation arrives
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= 16'h0000;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= add_v;
      if (add_v) begin
        result_o <= sum;
      end
    end
  end

endmodule

// File: tb/tb_traditional_multiplier8_xor_enc32.sv
// Bench for traditional_multiplier8_xor_enc32: scoreboard of expected products
// tagged with the cycle they must appear on; outputs sampled 1 ns after the edge.
module tb_traditional_multiplier8_xor_enc32;

  localparam logic [31:0] K = 32'h62FEDB15;
`ifdef TRADMUL8_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  operand1_i;
  logic [7:0]  operand2_i;
  logic [31:0] keyinput;
  logic        valid_i;
  logic [15:0] result_o;
  logic        valid_o;

  always #5 clk_i = ~clk_i;

  traditional_multiplier8_xor_enc32 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .keyinput   (keyinput),
    .valid_i    (valid_i),
    .result_o   (result_o),
    .valid_o    (valid_o)
  );

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] last_res = 16'h0000;
  bit          rst_chk  = 1'b0;

  // reference: weighted sum of key-gated partial products
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [31:0] key);
    logic [15:0] acc;
    logic        p;
    acc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        p = a[i] & b[j];
        if ((j % 2) == 0) p = p ^ key[i*4 + j/2] ^ K[i*4 + j/2];
        if (p) acc = acc + (16'h0001 << (i + j));
      end
    end
    return acc;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rst_chk) begin
      rst_chk = 1'b0;
      n_checks++;
      if (result_o !== 16'h0000 || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: result_o=%h valid_o=%b, required 0000/0", result_o, valid_o);
      end
    end else if (valid_o === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: cycle %0d result_o=%h with nothing outstanding", cyc, result_o);
      end else begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          n_fail++;
          $display("FAIL latency: result at cycle %0d, required cycle %0d", cyc, e.due);
        end
        n_checks++;
        if (result_o !== e.val) begin
          n_fail++;
          $display("FAIL result: cycle %0d result_o=%h, required %h", cyc, result_o, e.val);
        end
        last_res = e.val;
      end
    end else begin
      n_checks++;
      if (valid_o !== 1'b0 || result_o !== last_res) begin
        n_fail++;
        $display("FAIL hold: cycle %0d result_o=%h valid_o=%b, required %h/0", cyc, result_o, valid_o, last_res);
      end
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_fail++;
        $display("FAIL missing_result: cycle %0d, required %h due at %0d", cyc, sb[0].val, sb[0].due);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [31:0] key,
                       input logic v, input logic r, input logic [15:0] expv);
    exp_t e;
    operand1_i = a;
    operand2_i = b;
    keyinput   = key;
    valid_i    = v;
    rst_i      = r;
    if (r) begin
      sb.delete();
      last_res = 16'h0000;
      rst_chk  = 1'b1;
    end else if (v) begin
      e.val = expv;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 2; i++) drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    drive(8'hFF, 8'hFF, K, 1'b1, 1'b1, 16'h0000);
    drive(8'h12, 8'h34, K, 1'b1, 1'b1, 16'h0000);
    drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
    drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_directed();
    drive(8'h29, 8'h7A, K, 1'b1, 1'b0, 16'h138A);
    drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
    drive(8'h89, 8'hFF, K, 1'b1, 1'b0, 16'h8877);
    drive(8'h55, 8'hAA, K, 1'b1, 1'b0, 16'h3872);
    drive(8'h24, 8'h92, K, 1'b1, 1'b0, 16'h1488);
    drain();
  endtask

  task automatic test_boundaries();
    drive(8'hFF, 8'hFF, K, 1'b1, 1'b0, 16'hFE01);
    drive(8'h00, 8'h00, K, 1'b1, 1'b0, 16'h0000);
    drive(8'h80, 8'h80, K, 1'b1, 1'b0, 16'h4000);
    drive(8'hAB, 8'h00, K, 1'b1, 1'b0, 16'h0000);
    drain();
  endtask

  task automatic test_wrong_key();
    drive(8'h01, 8'h01, 32'h62FEDB14, 1'b1, 1'b0, 16'h0000);
    drive(8'h00, 8'h00, 32'h62FEDB14, 1'b1, 1'b0, 16'h0001);
    drive(8'hFE, 8'hFE, 32'h62FEDB14, 1'b1, 1'b0, 16'hFC05);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    for (int n = 0; n < 32; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      drive(a, b, K, 1'b1, 1'b0, 16'(int'(a) * int'(b)));
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    drive(8'h29, 8'h7A, K, 1'b1, 1'b0, 16'h138A);
    drive(8'h33, 8'h44, K, 1'b1, 1'b1, 16'h0000);
    drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
    drive(8'h00, 8'h00, K, 1'b0, 1'b0, 16'h0000);
    drive(8'h03, 8'h05, K, 1'b1, 1'b0, 16'h000F);
    drain();
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(8'(a), 8'(b), K, 1'b1, 1'b0, 16'(a * b));
      end
    end
    drain();
  endtask

  task automatic test_random_keys();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] key;
    logic        v;
    for (int n = 0; n < 600; n++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      key = $urandom;
      if (key == K) key = key ^ 32'h0000_0001;
      v   = ($urandom_range(0, 3) != 0);
      drive(a, b, key, v, 1'b0, model(a, b, key));
    end
    drain();
  endtask

  initial begin
    operand1_i = 8'h00;
    operand2_i = 8'h00;
    keyinput   = K;
    valid_i    = 1'b0;
    rst_i      = 1'b1;
    test_reset();
    test_directed();
    test_boundaries();
    test_wrong_key();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
